// File: rtl/router_read_sched.sv
// router_read_sched
//   Output-side read scheduler for the three-port router. It grants one
//   non-empty output FIFO at a time and drains exactly one packet (header,
//   payload, parity) from it. Each packet goes onto a single merged byte
//   stream that carries start/end markers and the source port number.
//
// Ports
//   clock, resetn              system clock, async active-low reset
//   valid_out_0/1/2            FIFO x non-empty
//   data_out_0/1/2             FIFO x read data (valid the cycle after read)
//   out_ready                  downstream credit for the byte returned next cycle
//   read_enb_0/1/2             FIFO x read strobe (only the granted port)
//   out_data/out_valid         merged stream beat
//   out_sop/out_eop            header / parity beat markers
//   out_port                   source FIFO of the current beat
//   abort                      one-cycle pulse: packet truncated by FIFO underflow
//
// Build option
//   ARB_FIXED_PRIO_EN          defined: fixed priority 0 > 1 > 2
//                              undefined: round-robin starting after last grant

module router_read_sched #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  valid_out_0,
   input  logic                  valid_out_1,
   input  logic                  valid_out_2,
   input  logic [DATA_WIDTH-1:0] data_out_0,
   input  logic [DATA_WIDTH-1:0] data_out_1,
   input  logic [DATA_WIDTH-1:0] data_out_2,
   input  logic                  out_ready,
   output logic                  read_enb_0,
   output logic                  read_enb_1,
   output logic                  read_enb_2,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [1:0]            out_port,
   output logic                  abort
);

   // state | meaning
   // IDLE  | waiting for any non-empty FIFO; grant is chosen here
   // HEAD  | header read issued once out_ready allows it
   // LEN   | header visible on data_out_gnt; load remaining-byte counter
   // BODY  | stream payload + parity, down-counting rem to the last read

   localparam int REM_W = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      LEN  = 2'd2,
      BODY = 2'd3
   } state_t;

   state_t                  state;
   logic [1:0]              gnt;
   logic [1:0]              next_gnt;
   logic [REM_W-1:0]        rem;
   logic [2:0]              valid_vec;
   logic                    gnt_valid;
   logic [DATA_WIDTH-1:0]   gnt_data;
   logic [DATA_WIDTH-3:0]   hdr_len;
   logic                    rd_fire;

   assign valid_vec = {valid_out_2, valid_out_1, valid_out_0};

   always_comb begin
      gnt_valid = 1'b0;
      gnt_data  = '0;
      case (gnt)
         2'd0: begin gnt_valid = valid_out_0; gnt_data = data_out_0; end
         2'd1: begin gnt_valid = valid_out_1; gnt_data = data_out_1; end
         2'd2: begin gnt_valid = valid_out_2; gnt_data = data_out_2; end
         default: ;
      endcase
   end

   assign hdr_len = gnt_data[DATA_WIDTH-1:2];

   // The read strobe has to follow out_ready and valid_out in the same cycle
   // (no skid buffer downstream), so it is decoded from the registered state.
   always_comb begin
      rd_fire = 1'b0;
      case (state)
         HEAD:    rd_fire = out_ready;
         BODY:    rd_fire = out_ready & gnt_valid;
         default: rd_fire = 1'b0;
      endcase
   end

   assign read_enb_0 = rd_fire && (gnt == 2'd0);
   assign read_enb_1 = rd_fire && (gnt == 2'd1);
   assign read_enb_2 = rd_fire && (gnt == 2'd2);

   // FIFO data arrives one cycle after the read, exactly when out_valid is up,
   // so the merged byte is a straight mux; gnt still points at the old port
   // during the IDLE cycle that carries the last beat.
   assign out_data = out_valid ? gnt_data : '0;
   assign out_port = gnt;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      if (valid_vec[0])      next_gnt = 2'd0;
      else if (valid_vec[1]) next_gnt = 2'd1;
      else                   next_gnt = 2'd2;
   end
`else
   logic [1:0] last_gnt;

   function automatic logic [1:0] rr_pick(input logic [2:0] v, input logic [1:0] last);
      logic [1:0] cand;
      logic [1:0] pick;
      logic       found;
      cand  = last;
      pick  = last;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
         if (!found && v[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb next_gnt = rr_pick(valid_vec, last_gnt);

   // Starts at port 2 so the first search after reset begins at port 0.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         last_gnt <= 2'd2;
      else if (state == IDLE && |valid_vec)
         last_gnt <= next_gnt;
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         gnt       <= 2'd0;
         rem       <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         abort     <= 1'b0;
      end else begin
         out_valid <= rd_fire;
         out_sop   <= rd_fire && (state == HEAD);
         out_eop   <= rd_fire && (state == BODY) && (rem == REM_W'(1));
         abort     <= 1'b0;
         case (state)
            IDLE: begin
               if (|valid_vec) begin
                  gnt   <= next_gnt;
                  state <= HEAD;
               end
            end
            HEAD: begin
               if (out_ready)
                  state <= LEN;
            end
            LEN: begin
               // payload bytes plus the trailing parity byte
               rem   <= REM_W'(hdr_len) + REM_W'(1);
               state <= BODY;
            end
            BODY: begin
               if (!gnt_valid) begin
                  abort <= 1'b1;
                  rem   <= '0;
                  state <= IDLE;
               end else if (out_ready) begin
                  rem <= rem - REM_W'(1);
                  if (rem == REM_W'(1))
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_read_sched.sv
// tb_router_read_sched
//   Self-checking bench for router_read_sched. Three behavioural FIFOs feed the
//   DUT; every loaded byte is pushed to a per-port scoreboard and popped when
//   the matching beat appears on the merged stream. A vector table covers
//   single-packet timing cases; hand-written sequences cover arbitration,
//   abort and mid-packet reset.

module tb_router_read_sched;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       valid_out_0, valid_out_1, valid_out_2;
   logic [7:0] data_out_0, data_out_1, data_out_2;
   logic       out_ready = 1'b1;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic [7:0] out_data;
   logic       out_valid, out_sop, out_eop, abort;
   logic [1:0] out_port;

   always #5 clock = ~clock;

   router_read_sched #(.DATA_WIDTH(8)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .valid_out_0 (valid_out_0),
      .valid_out_1 (valid_out_1),
      .valid_out_2 (valid_out_2),
      .data_out_0  (data_out_0),
      .data_out_1  (data_out_1),
      .data_out_2  (data_out_2),
      .out_ready   (out_ready),
      .read_enb_0  (read_enb_0),
      .read_enb_1  (read_enb_1),
      .read_enb_2  (read_enb_2),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_port    (out_port),
      .abort       (abort)
   );

   // ---------------- FIFO models ----------------
   logic [7:0] mem [3][256];
   logic [7:0] wr_ptr [3];
   logic [7:0] rd_ptr [3];
   logic [7:0] dq [3];

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 3; i++) begin
            rd_ptr[i] <= 8'd0;
            dq[i]     <= 8'd0;
         end
      end else begin
         if (read_enb_0) begin dq[0] <= mem[0][rd_ptr[0]]; rd_ptr[0] <= rd_ptr[0] + 8'd1; end
         if (read_enb_1) begin dq[1] <= mem[1][rd_ptr[1]]; rd_ptr[1] <= rd_ptr[1] + 8'd1; end
         if (read_enb_2) begin dq[2] <= mem[2][rd_ptr[2]]; rd_ptr[2] <= rd_ptr[2] + 8'd1; end
      end
   end

   assign valid_out_0 = (wr_ptr[0] != rd_ptr[0]);
   assign valid_out_1 = (wr_ptr[1] != rd_ptr[1]);
   assign valid_out_2 = (wr_ptr[2] != rd_ptr[2]);
   assign data_out_0  = dq[0];
   assign data_out_1  = dq[1];
   assign data_out_2  = dq[2];

   // ---------------- scoreboard / bookkeeping ----------------
   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
   } beat_t;

   beat_t sbq0[$];
   beat_t sbq1[$];
   beat_t sbq2[$];
   int    sop_log[$];

   int errors = 0;
   int checks = 0;
   int beats = 0;
   int multi_viol = 0;
   int rdy_viol = 0;
   logic [2:0] cur_ren;
   logic       cur_ov;
   logic       cur_abort;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic int sb_size(input int p);
      case (p)
         0: return sbq0.size();
         1: return sbq1.size();
         default: return sbq2.size();
      endcase
   endfunction

   task automatic push_byte(input int p, input logic [7:0] b);
      mem[p][wr_ptr[p]] = b;
      wr_ptr[p] = wr_ptr[p] + 8'd1;
   endtask

   task automatic expect_beat(input int p, input beat_t b);
      case (p)
         0: sbq0.push_back(b);
         1: sbq1.push_back(b);
         default: sbq2.push_back(b);
      endcase
   endtask

   // Writes a header with the given length, npay payload bytes and, if the
   // packet is complete, its parity byte; the same bytes are expected out.
   task automatic load_pkt(input int p, input int len, input int npay, input logic [1:0] lo);
      logic [5:0] l6;
      logic [7:0] hdr, b, par;
      l6  = 6'(len);
      hdr = {l6, lo};
      par = hdr;
      push_byte(p, hdr);
      expect_beat(p, {hdr, 1'b1, 1'b0});
      for (int i = 0; i < npay; i++) begin
         b   = 8'($urandom);
         par = par ^ b;
         push_byte(p, b);
         expect_beat(p, {b, 1'b0, 1'b0});
      end
      if (npay == len) begin
         push_byte(p, par);
         expect_beat(p, {par, 1'b0, 1'b1});
      end
   endtask

   task automatic sample();
      int    nren;
      beat_t got, exp;
      logic  have;
      nren = int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2);
      cur_ren   = {read_enb_2, read_enb_1, read_enb_0};
      cur_ov    = out_valid;
      cur_abort = abort;
      if (nren > 1) multi_viol++;
      if (nren > 0 && !out_ready) rdy_viol++;
      if (resetn && out_valid) begin
         got  = {out_data, out_sop, out_eop};
         exp  = '0;
         have = 1'b0;
         case (out_port)
            2'd0: if (sbq0.size() > 0) begin exp = sbq0.pop_front(); have = 1'b1; end
            2'd1: if (sbq1.size() > 0) begin exp = sbq1.pop_front(); have = 1'b1; end
            2'd2: if (sbq2.size() > 0) begin exp = sbq2.pop_front(); have = 1'b1; end
            default: have = 1'b0;
         endcase
         if (have) begin
            chk($sformatf("beat_port%0d", out_port), got, exp);
         end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: port=%0d data=0x%0h required=no beat", out_port, out_data);
         end
         if (out_sop) sop_log.push_back(int'(out_port));
         beats++;
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on
   // the falling edge.
   task automatic tick();
      @(negedge clock);
      sample();
      @(posedge clock);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          port;
      int          len;
      logic [1:0]  lo;
      logic [31:0] rdy;      // out_ready for cycle k (bit k), 1 beyond bit 31
      logic [15:0] exp_ren;  // read_enb of the port, bit k = cycle k after load
      logic [15:0] exp_ov;   // out_valid, bit k = cycle k after load
   } vec_t;

   vec_t tbl[5];

   initial begin
      int          exp_order[4];
      int          b0, a0;
      logic [15:0] ren_h, ov_h, ren0_h, ren1_h, ab_h;
      logic        other;
      logic [2:0]  all_zero;

      tbl[0] = '{port: 1, len: 3,  lo: 2'b01, rdy: 32'hFFFF_FFFF, exp_ren: 16'h007A, exp_ov: 16'h00F4};
      tbl[1] = '{port: 2, len: 0,  lo: 2'b10, rdy: 32'hFFFF_FFFF, exp_ren: 16'h000A, exp_ov: 16'h0014};
      tbl[2] = '{port: 0, len: 4,  lo: 2'b00, rdy: 32'hFFFF_FEAF, exp_ren: 16'h06AA, exp_ov: 16'h0D54};
      tbl[3] = '{port: 1, len: 63, lo: 2'b11, rdy: 32'hFFFF_FFFF, exp_ren: 16'hFFFA, exp_ov: 16'hFFF4};
      tbl[4] = '{port: 0, len: 1,  lo: 2'b00, rdy: 32'hFFFF_FFF9, exp_ren: 16'h0068, exp_ov: 16'h00D0};

      for (int i = 0; i < 3; i++) wr_ptr[i] = 8'd0;
      out_ready = 1'b1;
      resetn    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", {read_enb_0, read_enb_1, read_enb_2, out_valid, out_sop, out_eop,
                            abort, out_data, out_port}, 64'd0);
      resetn = 1'b1;
      tick();

      // ---- three simultaneous len=1 packets, port 0 refilled mid-sequence ----
`ifdef ARB_FIXED_PRIO_EN
      exp_order = '{0, 1, 0, 2};
`else
      exp_order = '{0, 1, 2, 0};
`endif
      sop_log.delete();
      load_pkt(0, 1, 1, 2'b00);
      load_pkt(1, 1, 1, 2'b01);
      load_pkt(2, 1, 1, 2'b10);
      for (int k = 0; k < 40; k++) begin
         if (k == 6) load_pkt(0, 1, 1, 2'b11);
         tick();
      end
      chk("arb_grant_count", sop_log.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("arb_order_%0d", i), (i < sop_log.size()) ? sop_log[i] : 99, exp_order[i]);
      chk("arb_scoreboard_drained", sb_size(0) + sb_size(1) + sb_size(2), 0);

      // ---- single-packet vectors ----
      for (int e = 0; e < 5; e++) begin
         sop_log.delete();
         b0    = beats;
         ren_h = '0;
         ov_h  = '0;
         other = 1'b0;
         load_pkt(tbl[e].port, tbl[e].len, tbl[e].len, tbl[e].lo);
         for (int k = 0; k < 100; k++) begin
            out_ready = (k < 32) ? tbl[e].rdy[k] : 1'b1;
            tick();
            if (k < 16) begin
               ren_h[k] = cur_ren[tbl[e].port];
               ov_h[k]  = cur_ov;
            end
            for (int j = 0; j < 3; j++)
               if (j != tbl[e].port) other = other | cur_ren[j];
         end
         out_ready = 1'b1;
         chk($sformatf("vec%0d_read_enb", e), ren_h, tbl[e].exp_ren);
         chk($sformatf("vec%0d_out_valid", e), ov_h, tbl[e].exp_ov);
         chk($sformatf("vec%0d_other_port_read", e), other, 1'b0);
         chk($sformatf("vec%0d_beats", e), beats - b0, tbl[e].len + 2);
         chk($sformatf("vec%0d_sop_port", e), (sop_log.size() == 1) ? sop_log[0] : 99, tbl[e].port);
         chk($sformatf("vec%0d_drained", e), sb_size(tbl[e].port), 0);
      end

      // ---- abort: len=6 header but only 2 payload bytes present ----
      ren0_h = '0;
      ren1_h = '0;
      ab_h   = '0;
      load_pkt(0, 6, 2, 2'b01);
      for (int k = 0; k < 20; k++) begin
         if (k == 5) load_pkt(1, 0, 0, 2'b00);
         tick();
         if (k < 16) begin
            ren0_h[k] = cur_ren[0];
            ren1_h[k] = cur_ren[1];
            ab_h[k]   = cur_abort;
         end
      end
      chk("abort_read_enb_0", ren0_h, 16'h001A);
      chk("abort_pulse", ab_h, 16'h0040);
      chk("abort_then_idle_grant", ren1_h, 16'h0280);
      chk("abort_port0_drained", sb_size(0), 0);
      chk("abort_port1_drained", sb_size(1), 0);

      // ---- asynchronous reset in the middle of BODY ----
      load_pkt(1, 8, 8, 2'b00);
      for (int k = 0; k < 5; k++) tick();
      chk("pre_reset_body_read", cur_ren[1], 1'b1);
      #2;
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) wr_ptr[i] = 8'd0;
      sbq0.delete();
      sbq1.delete();
      sbq2.delete();
      #1;
      chk("reset_mid_body_outputs", {read_enb_0, read_enb_1, read_enb_2, out_valid, out_sop, out_eop,
                                     abort, out_data, out_port}, 64'd0);
      all_zero = {valid_out_2, valid_out_1, valid_out_0};
      chk("reset_fifos_empty", all_zero, 3'b000);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      sop_log.delete();
      load_pkt(2, 1, 1, 2'b00);
      load_pkt(0, 1, 1, 2'b00);
      for (int k = 0; k < 30; k++) tick();
      chk("post_reset_grant_count", sop_log.size(), 2);
      chk("post_reset_first_grant", (sop_log.size() > 0) ? sop_log[0] : 99, 0);
      chk("post_reset_second_grant", (sop_log.size() > 1) ? sop_log[1] : 99, 2);
      chk("post_reset_drained", sb_size(0) + sb_size(2), 0);

      a0 = 0;
      chk("read_enb_onehot", multi_viol, a0);
      chk("read_only_when_ready", rdy_viol, a0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/router_read_sched.md
# router_read_sched

Output-side read scheduler for the three-port router. It watches the valid flags of the three output FIFOs, grants one FIFO at a time, and drains exactly one whole packet (header, payload, parity) per grant. The packet is delivered onto a single merged output stream with start/end markers and the source port number. It sits between the FIFO outputs (valid_out_x, data_out_x) and a single downstream consumer, and it owns the read_enb_x lines.

## Interface
- DATA_WIDTH, 8: byte width. Header payload length is field [DATA_WIDTH-1:2].
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- valid_out_0/1/2  in  1  FIFO x non-empty
- data_out_0/1/2  in  DATA_WIDTH  FIFO x read data, valid the cycle after read_enb_x
- out_ready  in  1  downstream credit for the byte returned next cycle
- read_enb_0/1/2  out  1  FIFO x read strobe; at most one high per cycle
- out_data  out  DATA_WIDTH  merged byte stream
- out_valid  out  1  out_data valid this cycle
- out_sop  out  1  out_valid beat is a header
- out_eop  out  1  out_valid beat is a parity byte
- out_port  out  2  source FIFO of the current beat (0..2)
- abort  out  1  one-cycle pulse: packet truncated

## Operation
- States: IDLE, HEAD, LEN, BODY.
- IDLE: if any valid_out_x is set, pick a grant port (see Configuration), register it in gnt, and go to HEAD. Otherwise stay in IDLE.
- HEAD: assert read_enb_gnt when out_ready=1, then go to LEN. If out_ready=0, hold in HEAD.
- LEN: no read. The header is on data_out_gnt. Latch len = header[DATA_WIDTH-1:2] and load rem = len+1 (payload plus parity; 7-bit counter). Go to BODY.
- BODY: assert read_enb_gnt when out_ready=1 and valid_out_gnt=1, and decrement rem on each read.
  - The read made with rem==1 ends the packet. Go to IDLE.
  - If valid_out_gnt=0 while rem>0 (FIFO soft-reset or underflow): pulse abort, go to IDLE, and issue no further reads on that port.
- Output path:
  - out_valid is read_enb_gnt delayed one cycle.
  - out_data = data_out_gnt, muxed by gnt.
  - out_port = gnt.
  - out_sop marks the beat from the HEAD read. out_eop marks the beat from the rem==1 read.
- len=0 is legal: header then parity, 2 beats total.
- read_enb_x is never asserted for a non-granted port.

## Timing
- Reset values: all read_enb_x=0, out_valid=0, out_sop=0, out_eop=0, abort=0, out_data=0, out_port=0, state=IDLE, rem=0.
- Arbitration: IDLE→HEAD takes 1 cycle. The header read can start at the earliest in the cycle after the valid flag is seen.
- Read-to-output latency: 1 cycle. A beat read at t is on out_data at t+1.
- The downstream must accept every beat whose read was made while out_ready=1. There is no skid buffer.
- Throughput:
  - LEN inserts exactly one bubble after the header.
  - The body streams 1 byte/cycle while out_ready=1.
  - A minimum packet (len=0) takes IDLE, HEAD, LEN, BODY = 4 cycles from grant to last read.
- Back-to-back packets: after the final read the FSM is in IDLE, so there is a 1-cycle idle gap, then a new grant.
- resetn low mid-packet immediately clears all outputs and the FSM. The partial packet is not resumed.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, port 0 > 1 > 2.
- ARB_FIXED_PRIO_EN undefined (default): round-robin. The search starts at the port after the last grant; after reset the last grant is port 2, so port 0 is searched first.

## Test plan
- Single packet on FIFO 1: header 0x0D (len=3) + 3 payload + parity, out_ready=1.
  - read_enb_1 is high for 5 reads, with one bubble after the header.
  - out_port=1; out_sop on 0x0D; out_eop on the parity byte; 5 out_valid beats.
- All three FIFOs hold a len=1 packet at the same time.
  - Round-robin: grant order 0,1,2.
  - With ARB_FIXED_PRIO_EN: order 0,1,2, and a refilled port 0 pre-empts port 2 at the next IDLE.
- Backpressure: out_ready toggles 1,0,1,0 during the BODY of a len=4 packet. A read is issued only in out_ready=1 cycles, with no lost or duplicated bytes.
- Zero-length packet: header 0x02 (len=0) on FIFO 2. Exactly 2 beats; the second has out_eop=1.
- Abort: valid_out_0 drops after 2 payload reads of a len=6 packet. abort pulses once, no further read_enb_0, and the FSM is in IDLE the next cycle.
- Reset mid-BODY: resetn is pulled low asynchronously. All outputs are 0 within the same cycle; after release, the first grant goes to port 0.
